muldiv_hilo_ctrl: RTL and testbench

- EX-stage controller that sits directly upstream of the pipelined multiplier and downstream of its result.
- Latches operands and holds them stable into the multiplier. Drives `in_valid` and `sign`, waits for `out_valid`, then commits the product into the architectural HI/LO registers.
- Raises a pipeline stall while a multiply is in flight.
- Also executes MTHI/MTLO, serves MFHI/MFLO reads with same-cycle forwarding, and aborts cleanly on exception flush.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 23 ++
 rtl/muldiv_hilo_ctrl_if.sv | 22 ++
 rtl/muldiv_hilo_ctrl_regfile.sv | 34 +++
 rtl/muldiv_hilo_ctrl.sv | 135 +++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared types for the HI/LO multiply controller: EX-stage opcodes and FSM states.
package hilo_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      MULT  = 3'd1,
      MULTU = 3'd2,
      MTHI  = 3'd3,
      MTLO  = 3'd4
   } hilo_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } hilo_state_t;

   // True for the two opcodes that go through the pipelined multiplier.
   function automatic logic is_mul_op(input hilo_op_t op);
      return (op == MULT) || (op == MULTU);
   endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// Handshake between the HI/LO controller (master) and the pipelined multiplier (slave).
interface muldiv_hilo_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             mul_in_valid;
   logic             mul_sign;
   logic [WIDTH-1:0] mul_srca;
   logic [WIDTH-1:0] mul_srcb;
   logic             mul_out_valid;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;

   modport master (
      output mul_in_valid, mul_sign, mul_srca, mul_srcb,
      input  mul_out_valid, mul_hi, mul_lo
   );

   modport slave (
      input  mul_in_valid, mul_sign, mul_srca, mul_srcb,
      output mul_out_valid, mul_hi, mul_lo
   );
endinterface

// File: rtl/muldiv_hilo_ctrl_regfile.sv
// Architectural HI/LO registers with write-through forwarding to the MFHI/MFLO read ports.
module hilo_regfile #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hi_we,
   input  logic [WIDTH-1:0] hi_wd,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] lo_wd,
   output logic [WIDTH-1:0] hi_rd,
   output logic [WIDTH-1:0] lo_rd
);

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // HI/LO storage; reset clears both, so a reset in the commit cycle drops the write.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (hi_we) hi_q <= hi_wd;
         if (lo_we) lo_q <= lo_wd;
      end
   end

   // A reader in the same cycle as a write sees the new value.
   assign hi_rd = hi_we ? hi_wd : hi_q;
   assign lo_rd = lo_we ? lo_wd : lo_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage HI/LO controller: issues MULT/MULTU to the multiplier with held operands,
// stalls the pipe while in flight, commits the product, and handles MTHI/MTLO and flush.
module muldiv_hilo_ctrl
   import hilo_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   input  hilo_op_t           ex_op,
   input  logic [WIDTH-1:0]   ex_srca,
   input  logic [WIDTH-1:0]   ex_srcb,
   input  logic               ex_adv,
   input  logic               flush,
   output logic               stall_req,
   muldiv_hilo_ctrl_if.master mul,
   output logic [WIDTH-1:0]   hi_rd,
   output logic [WIDTH-1:0]   lo_rd,
   output logic               err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   hilo_state_t      state;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic             sign_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   logic             start;
   logic             commit;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] hi_wd;
   logic [WIDTH-1:0] lo_wd;

   // Decode this cycle's HI/LO writes: multiply commit, or MTHI/MTLO from IDLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      start  = 1'b0;
      commit = 1'b0;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      hi_wd  = mul.mul_hi;
      lo_wd  = mul.mul_lo;

      if (state == IDLE && ex_valid && !flush) begin
         start = is_mul_op(ex_op);
         if (ex_op == MTHI) begin
            hi_we = 1'b1;
            hi_wd = ex_srca;
         end
         if (ex_op == MTLO) begin
            lo_we = 1'b1;
            lo_wd = ex_srca;
         end
      end

      // Flush squashes the commit even when the product arrives in the same cycle.
      if (state == BUSY && mul.mul_out_valid && !flush) begin
         commit = 1'b1;
         hi_we  = 1'b1;
         lo_we  = 1'b1;
      end
   end

   // Issue/wait/commit FSM with operand, sign and timeout registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         opa_q  <= '0;
         opb_q  <= '0;
         sign_q <= 1'b0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  opa_q  <= ex_srca;
                  opb_q  <= ex_srcb;
                  sign_q <= (ex_op == MULT);
                  cnt_q  <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
               end else if (commit) begin
                  state <= DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               // Wait for the multiply to leave EX so an unrelated stall cannot re-issue it.
               if (flush || ex_adv) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The stall is raised in the issue cycle itself so the MULT cannot advance.
   assign stall_req = start || (state == BUSY);

   // Operands and sign come straight from registers, so they are stable for all of BUSY.
   assign mul.mul_in_valid = (state == BUSY);
   assign mul.mul_sign     = sign_q;
   assign mul.mul_srca     = opa_q;
   assign mul.mul_srcb     = opb_q;
   assign err_timeout      = err_q;

   hilo_regfile #(
      .WIDTH(WIDTH)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .hi_we (hi_we),
      .hi_wd (hi_wd),
      .lo_we (lo_we),
      .lo_wd (lo_wd),
      .hi_rd (hi_rd),
      .lo_rd (lo_rd)
   );

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed scenarios plus randomized
// instruction mix against a transaction-level HI/LO model.
module tb_muldiv_hilo_ctrl;
   import hilo_pkg::*;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 15;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        ex_valid = 1'b0;
   hilo_op_t    ex_op    = NONE;
   logic [31:0] ex_srca  = '0;
   logic [31:0] ex_srcb  = '0;
   logic        flush    = 1'b0;
   logic        hold_adv = 1'b0;
   logic        mul_en   = 1'b1;
   logic        ex_adv;
   logic        stall_req;
   logic        err_timeout;
   logic [31:0] hi_rd;
   logic [31:0] lo_rd;

   int n_vec = 0;
   int n_bad = 0;

   // Architectural HI/LO as the instruction stream should leave them.
   logic [31:0] mdl_hi = '0;
   logic [31:0] mdl_lo = '0;

   muldiv_hilo_ctrl_if #(.WIDTH(WIDTH)) mif ();

   muldiv_hilo_ctrl #(
      .WIDTH  (WIDTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid   (ex_valid),
      .ex_op      (ex_op),
      .ex_srca    (ex_srca),
      .ex_srcb    (ex_srcb),
      .ex_adv     (ex_adv),
      .flush      (flush),
      .stall_req  (stall_req),
      .mul        (mif),
      .hi_rd      (hi_rd),
      .lo_rd      (lo_rd),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // The EX instruction leaves whenever it is not stalled, unless the bench holds it.
   assign ex_adv = !stall_req && !hold_adv;

   function automatic logic [63:0] full_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic s);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         return 64'(sa * sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
   endfunction

   // Multiplier stand-in: answers once operands have been held for 3 consecutive cycles.
   int unsigned m_cnt = 0;
   logic [31:0] m_a   = '0;
   logic [31:0] m_b   = '0;
   logic        m_s   = 1'b0;
   logic [63:0] m_prod;

   always @(posedge clk) begin
      if (!mif.mul_in_valid)
         m_cnt <= 0;
      else if (m_cnt != 0 && (mif.mul_srca != m_a || mif.mul_srcb != m_b || mif.mul_sign != m_s))
         m_cnt <= 1;
      else if (m_cnt < 7)
         m_cnt <= m_cnt + 1;
      m_a <= mif.mul_srca;
      m_b <= mif.mul_srcb;
      m_s <= mif.mul_sign;
   end

   always_comb m_prod = full_product(mif.mul_srca, mif.mul_srcb, mif.mul_sign);
   assign mif.mul_out_valid = mul_en && mif.mul_in_valid && (m_cnt >= 3);
   assign mif.mul_hi        = m_prod[63:32];
   assign mif.mul_lo        = m_prod[31:0];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      ex_valid = 1'b0;
      ex_op    = NONE;
      flush    = 1'b0;
      hold_adv = 1'b0;
      mul_en   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mdl_hi = '0;
      mdl_lo = '0;
   endtask

   // One IDLE-cycle instruction that must not stall: NONE, MTHI, MTLO, or a flushed op.
   task automatic idle_op(input hilo_op_t op, input logic [31:0] v, input logic fl);
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      exp_hi   = (!fl && op == MTHI) ? v : mdl_hi;
      exp_lo   = (!fl && op == MTLO) ? v : mdl_lo;
      ex_valid = 1'b1;
      ex_op    = op;
      ex_srca  = v;
      ex_srcb  = $urandom;
      flush    = fl;
      @(negedge clk);
      check("idle_stall", stall_req, 0);
      check("idle_fwd_hi", hi_rd, exp_hi);
      check("idle_fwd_lo", lo_rd, exp_lo);
      next_cycle();
      ex_valid = 1'b0;
      ex_op    = NONE;
      flush    = 1'b0;
      mdl_hi   = exp_hi;
      mdl_lo   = exp_lo;
      @(negedge clk);
      check("idle_after_inv", mif.mul_in_valid, 0);
      check("idle_after_hi", hi_rd, mdl_hi);
      check("idle_after_lo", lo_rd, mdl_lo);
      next_cycle();
   endtask

   // Multiply scenario. mode: 0 normal, 1 change rs during BUSY, 2 flush in the
   // result cycle, 3 reset during BUSY, 4 multiplier never answers (timeout).
   task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input hilo_op_t op,
                            input int mode, input int hold);
      logic        sgn;
      logic [63:0] exp;
      int          busy;
      logic        done;
      sgn      = (op == MULT);
      exp      = full_product(a, b, sgn);
      ex_valid = 1'b1;
      ex_op    = op;
      ex_srca  = a;
      ex_srcb  = b;
      if (mode == 4) mul_en = 1'b0;
      @(negedge clk);
      check("issue_stall", stall_req, 1);
      check("issue_inv", mif.mul_in_valid, 0);
      next_cycle();

      busy = 0;
      done = 1'b0;
      while (!done && busy < 40) begin
         busy++;
         if (mode == 1 && busy == 2) ex_srca = ~a;
         if (mode == 3 && busy == 2) begin
            rst_n = 1'b0;
            next_cycle();
            rst_n    = 1'b1;
            ex_valid = 1'b0;
            ex_op    = NONE;
            mdl_hi   = '0;
            mdl_lo   = '0;
            @(negedge clk);
            check("rst_stall", stall_req, 0);
            check("rst_inv", mif.mul_in_valid, 0);
            check("rst_hi", hi_rd, 0);
            check("rst_lo", lo_rd, 0);
            next_cycle();
            return;
         end
         if (mode == 2 && mif.mul_out_valid) flush = 1'b1;
         @(negedge clk);
         check("busy_stall", stall_req, 1);
         check("busy_inv", mif.mul_in_valid, 1);
         check("busy_srca", mif.mul_srca, a);
         check("busy_srcb", mif.mul_srcb, b);
         check("busy_sign", mif.mul_sign, sgn);
         check("busy_err", err_timeout, 0);
         if (mif.mul_out_valid) begin
            done = 1'b1;
            if (mode != 2) begin
               check("commit_fwd_hi", hi_rd, exp[63:32]);
               check("commit_fwd_lo", lo_rd, exp[31:0]);
            end
         end
         if (mode == 4 && busy == TIMEOUT) done = 1'b1;
         if (!done) next_cycle();
      end
      if (!done) check("busy_cycle_bound", 0, 1);
      next_cycle();

      if (mode == 2) begin
         flush    = 1'b0;
         ex_valid = 1'b0;
         ex_op    = NONE;
         @(negedge clk);
         check("flush_inv", mif.mul_in_valid, 0);
         check("flush_stall", stall_req, 0);
         check("flush_hi", hi_rd, mdl_hi);
         check("flush_lo", lo_rd, mdl_lo);
         next_cycle();
         return;
      end

      if (mode == 4) begin
         ex_valid = 1'b0;
         ex_op    = NONE;
         mul_en   = 1'b1;
         @(negedge clk);
         check("tmo_err", err_timeout, 1);
         check("tmo_inv", mif.mul_in_valid, 0);
         check("tmo_stall", stall_req, 0);
         check("tmo_hi", hi_rd, mdl_hi);
         check("tmo_lo", lo_rd, mdl_lo);
         next_cycle();
         @(negedge clk);
         check("tmo_err_pulse", err_timeout, 0);
         next_cycle();
         return;
      end

      mdl_hi   = exp[63:32];
      mdl_lo   = exp[31:0];
      hold_adv = (hold != 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_inv", mif.mul_in_valid, 0);
         check("hold_stall", stall_req, 0);
         next_cycle();
      end
      hold_adv = 1'b0;
      @(negedge clk);
      check("done_stall", stall_req, 0);
      check("done_inv", mif.mul_in_valid, 0);
      check("done_hi", hi_rd, mdl_hi);
      check("done_lo", lo_rd, mdl_lo);
      next_cycle();
      ex_valid = 1'b0;
      ex_op    = NONE;
      @(negedge clk);
      check("post_idle_inv", mif.mul_in_valid, 0);
      next_cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hilo_op_t    op;
      logic [31:0] v;
      int          k;

      do_reset();
      @(negedge clk);
      check("rst_stall", stall_req, 0);
      check("rst_inv", mif.mul_in_valid, 0);
      check("rst_sign", mif.mul_sign, 0);
      check("rst_err", err_timeout, 0);
      check("rst_srca", mif.mul_srca, 0);
      check("rst_hi", hi_rd, 0);
      check("rst_lo", lo_rd, 0);
      next_cycle();

      // Signed and unsigned products of the same operands.
      issue_mul(32'hFFFF_FFFE, 32'h0000_0003, MULT, 0, 0);
      @(negedge clk);
      check("mult_hi_const", hi_rd, 32'hFFFF_FFFF);
      check("mult_lo_const", lo_rd, 32'hFFFF_FFFA);
      next_cycle();
      issue_mul(32'hFFFF_FFFE, 32'h0000_0003, MULTU, 0, 0);
      @(negedge clk);
      check("multu_hi_const", hi_rd, 32'h0000_0002);
      check("multu_lo_const", lo_rd, 32'hFFFF_FFFA);
      next_cycle();

      // rs changes under a stalled MULTU; the latched value is used.
      issue_mul(32'd5, 32'd7, MULTU, 1, 0);
      @(negedge clk);
      check("stable_lo_const", lo_rd, 32'd35);
      next_cycle();

      // Flush in the result cycle leaves HI/LO at their reset values.
      do_reset();
      issue_mul($urandom, $urandom, MULT, 2, 0);
      @(negedge clk);
      check("flush_hi_const", hi_rd, 0);
      check("flush_lo_const", lo_rd, 0);
      next_cycle();

      // DONE hold, then the next MULT (same operands) issues normally.
      issue_mul(32'h0001_0000, 32'h0001_0000, MULTU, 0, 3);
      issue_mul(32'h0001_0000, 32'h0001_0000, MULTU, 0, 0);
      @(negedge clk);
      check("hold_hi_const", hi_rd, 32'h0000_0001);
      check("hold_lo_const", lo_rd, 32'h0000_0000);
      next_cycle();

      // MTLO forwarding, then reset during BUSY.
      idle_op(MTLO, 32'h1234_5678, 1'b0);
      issue_mul(32'h0000_0009, 32'h0000_0009, MULT, 3, 0);
      @(negedge clk);
      check("rst_busy_lo_const", lo_rd, 0);
      next_cycle();

      // Multiplier silent: timeout pulse, no write.
      idle_op(MTHI, 32'hCAFE_F00D, 1'b0);
      issue_mul($urandom, $urandom, MULT, 4, 0);

      // Randomized instruction mix.
      for (int i = 0; i < 40; i++) begin
         op = hilo_op_t'($urandom_range(0, 4));
         v  = $urandom;
         k  = $urandom_range(0, 9);
         if (is_mul_op(op) && k != 0)
            issue_mul(v, $urandom, op, (k == 1) ? 2 : (k == 2) ? 1 : 0, (k == 3) ? 2 : 0);
         else
            idle_op(op, v, (k == 0 || $urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
